// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with RX/TX FIFOs, a fixed baud divider
// derived from CLK_FREQ/BAUD, and sticky error flags.
//   clk, rst_n     system clock, asynchronous active-low reset
//   rxd, txd       serial in (asynchronous to clk) / serial out
//   ce_i, we_i     bus strobe and write select
//   addr_i         0 = DATA, 1 = STATUS
//   data_i, sel_i  write data and byte enables (only sel_i[0] is used)
//   data_o         read data, combinational from addr_i
//   rx_irq         registered "RX FIFO non-empty"
module uart_mmio #(
  parameter int unsigned CLK_FREQ = 10000000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic        txd,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic        addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        rx_irq
);

  localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned CW    = $clog2(DIV);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);

  if (DIV < 4) begin : g_bad_div
    $error("uart_mmio: baud divider below 4");
  end
  if (RX_DEPTH < 2 || RX_DEPTH > 256 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_bad_rx_depth
    $error("uart_mmio: RX_DEPTH must be a power of two in 2..256");
  end
  if (TX_DEPTH < 2 || TX_DEPTH > 256 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_bad_tx_depth
    $error("uart_mmio: TX_DEPTH must be a power of two in 2..256");
  end

  // Bus decode
  logic data_rd, data_wr, stat_wr;
  assign data_rd = ce_i & ~we_i & ~addr_i;
  assign data_wr = ce_i &  we_i & ~addr_i & sel_i[0];
  assign stat_wr = ce_i &  we_i &  addr_i & sel_i[0];

  logic unused_bits;
  assign unused_bits = ^{sel_i[3:1], data_i[31:8]};

  // ---------------- RX path ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t     rx_state;
  logic          rxd_meta, rxd_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_push, rx_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      unique case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (!rxd_sync) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // Line back high at mid start bit: treat as a glitch.
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CW'(DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CW'(DIV - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            rx_push  <= rxd_sync;
            rx_ferr  <= ~rxd_sync;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // RX FIFO: pointers carry one extra bit to tell full from empty.
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RX_AW:0] rx_wptr, rx_rptr, rx_used;
  logic           rx_empty, rx_full, rx_pop, rx_accept;
  logic [8:0]     rx_used9;
  logic [7:0]     rx_occ, rx_head;

  assign rx_used   = rx_wptr - rx_rptr;
  assign rx_empty  = (rx_wptr == rx_rptr);
  assign rx_full   = (rx_wptr[RX_AW] != rx_rptr[RX_AW]) &&
                     (rx_wptr[RX_AW-1:0] == rx_rptr[RX_AW-1:0]);
  assign rx_pop    = data_rd & ~rx_empty;
  assign rx_accept = rx_push & ~rx_full;
  assign rx_head   = rx_mem[rx_rptr[RX_AW-1:0]];
  assign rx_used9  = 9'(rx_used);
  assign rx_occ    = rx_used9[8] ? 8'hFF : rx_used9[7:0];

  always_ff @(posedge clk) begin
    if (rx_accept) rx_mem[rx_wptr[RX_AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (rx_accept) rx_wptr <= rx_wptr + 1'b1;
      if (rx_pop)    rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // ---------------- TX path ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t      tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_shift;
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TX_AW:0] tx_wptr, tx_rptr, tx_used;
  logic           tx_empty, tx_full, tx_pop, tx_accept, tx_bit_end;
  logic [8:0]     tx_used9;
  logic [7:0]     tx_occ, tx_head;

  assign tx_used    = tx_wptr - tx_rptr;
  assign tx_empty   = (tx_wptr == tx_rptr);
  assign tx_full    = (tx_wptr[TX_AW] != tx_rptr[TX_AW]) &&
                      (tx_wptr[TX_AW-1:0] == tx_rptr[TX_AW-1:0]);
  assign tx_bit_end = (tx_cnt == CW'(DIV - 1));
  // Popping on the last stop-bit cycle chains frames with no idle gap.
  assign tx_pop     = ~tx_empty & ((tx_state == TX_IDLE) |
                                   ((tx_state == TX_STOP) & tx_bit_end));
  assign tx_accept  = data_wr & (~tx_full | tx_pop);
  assign tx_head    = tx_mem[tx_rptr[TX_AW-1:0]];
  assign tx_used9   = 9'(tx_used);
  assign tx_occ     = tx_used9[8] ? 8'hFF : tx_used9[7:0];

  always_ff @(posedge clk) begin
    if (tx_accept) tx_mem[tx_wptr[TX_AW-1:0]] <= data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
    end else begin
      if (tx_accept) tx_wptr <= tx_wptr + 1'b1;
      if (tx_pop)    tx_rptr <= tx_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      unique case (tx_state)
        TX_IDLE: begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_shift <= tx_head;
            txd      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              txd      <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              txd      <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_pop) begin
              tx_shift <= tx_head;
              txd      <= 1'b0;
              tx_state <= TX_START;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CW'(1);
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // ---------------- Flags and IRQ ----------------
  logic rx_overrun, frame_err, tx_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
      rx_irq     <= 1'b0;
    end else begin
      rx_overrun <= (rx_push & rx_full)      | (rx_overrun & ~(stat_wr & data_i[2]));
      frame_err  <= rx_ferr                  | (frame_err  & ~(stat_wr & data_i[3]));
      tx_drop    <= (data_wr & ~tx_accept)   | (tx_drop    & ~(stat_wr & data_i[4]));
      rx_irq     <= ~rx_empty;
    end
  end

  always_comb begin
    data_o = '0;
    if (rst_n) begin
      if (!addr_i) begin
        data_o[7:0] = rx_empty ? 8'h00 : rx_head;
      end else begin
        data_o[0]     = ~tx_full;
        data_o[1]     = ~rx_empty;
        data_o[2]     = rx_overrun;
        data_o[3]     = frame_err;
        data_o[4]     = tx_drop;
        data_o[5]     = tx_empty & (tx_state == TX_IDLE);
        data_o[15:8]  = rx_occ;
        data_o[23:16] = tx_occ;
      end
    end
  end

endmodule
